rr_arbiter8: RTL and testbench
==============================

Name: rr_arbiter8

Overview:
- 8-requester arbiter sharing one resource, with a 3-bit grant index in the same format as the 8-to-3 priority encoder output.
- Two selectable policies:
  - fixed priority: highest set index wins, identical to the encoder's priority order.
  - round-robin: rotating pointer.
- Grant is held while the owner keeps requesting, bounded by a hold-limit timeout.
- Sits between N masters and a single shared datapath port; gnt_id drives the downstream mux select.

Parameters:
- N, 8, number of requesters (fixed at 8 for this revision; IDX_W derived).
- IDX_W, 3, width of grant index, equals clog2(N).
- MAX_HOLD, 16, maximum consecutive cycles one owner may hold the grant while others wait; legal range 2..255.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  synchronous active-high reset.
- req  input  8  request vector, one bit per requester; a requester holds its bit high until it no longer needs the resource.
- fixed_pri  input  1  1 = fixed priority (index 7 highest), 0 = round-robin; sampled only at arbitration points.
- gnt  output  8  one-hot grant, all zero when idle.
- gnt_id  output  3  binary index of current owner; 3'b000 when idle.
- gnt_valid  output  1  high while any grant is active.

Behaviour:
- Clock and reset:
  - One clock (clk).
  - Reset is synchronous and active-high (rst); sampled only on posedge clk.
  - On reset: gnt=8'h00, gnt_id=3'b000, gnt_valid=0, ptr=3'b000, hold_cnt=0, state=IDLE.
  - rst asserted mid-grant drops the grant at that same edge. No partial state survives reset.
- All outputs are registered. Latency from req assertion in IDLE to gnt asserted is 1 cycle.
- States: IDLE, GRANT.
- IDLE:
  - If req==0, stay in IDLE.
  - Else pick a winner, load gnt/gnt_id, set gnt_valid=1, hold_cnt=0, ptr=winner+1 mod 8, and go to GRANT.
- Winner selection:
  - fixed_pri=1: highest set index of the candidate vector.
  - fixed_pri=0: first set index searching upward from ptr, wrapping 7->0.
- GRANT, evaluated each edge in this order:
  - Release: req[gnt_id]==0.
    - If another request is pending, re-arbitrate at the same edge (back-to-back handoff, no idle cycle).
    - Otherwise go to IDLE and clear gnt, gnt_id and gnt_valid.
  - Timeout: req[gnt_id]==1, hold_cnt==MAX_HOLD-1, and some other bit of req is set.
    - Re-arbitrate with the current owner masked out.
    - The new owner gets the grant next edge; the old owner must re-compete later.
  - Timeout with no competitor: keep the grant and reset hold_cnt to 0.
  - Otherwise: hold the grant and increment hold_cnt, saturating at MAX_HOLD-1.
- Re-arbitration always updates ptr=winner+1 mod 8 in both modes. ptr wraps 7->0.
- A fixed_pri change during GRANT has no effect until the next arbitration point.
- A requester that drops and re-raises req in the same cycle as another's release is treated by its sampled value only.
- Invariants:
  - gnt is zero or one-hot.
  - gnt_valid == |gnt.
  - gnt_id == encode(gnt).
  - gnt never names a requester whose req was 0 at the arbitration edge.

Decomposition:
- Package arb_pkg: N, IDX_W, state type {IDLE, GRANT}, hold-counter width constant.
- One combinational sub-module, arb_pick.
  - Inputs: candidate vector, ptr, mode.
  - Outputs: winner index and found flag.
  - Implemented as a rotate, fixed priority encode, un-rotate.
  - Used for both normal and owner-masked arbitration.

Test Plan:
- Reset then req=8'h00 for 5 cycles -> gnt=8'h00, gnt_id=0, gnt_valid=0 throughout.
- fixed_pri=1, req=8'b0001_0101 -> 1 cycle later gnt=8'h10, gnt_id=3'b100. Then drop req[4] -> next edge gnt=8'h04, gnt_id=3'b010.
- fixed_pri=0, ptr=0, all 8 requesters pulse 1-cycle releases -> grants visit 0,1,2,...,7,0 in order, each handoff with no idle cycle.
- MAX_HOLD=4, req[3] held high with req[5] high -> gnt_id=3 for exactly 4 cycles, then gnt_id=5. With req[3] alone high -> gnt_id=3 stays indefinitely.
- rst asserted while gnt_id=6 -> next edge gnt=0, gnt_valid=0, ptr=0. After rst drops with req=8'hFF and fixed_pri=0 -> gnt_id=0.
- Toggle fixed_pri mid-grant with req=8'b1000_0010 and owner=1 in RR mode -> owner unchanged until release. At release the new mode is applied: fixed gives 7.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared constants, state type and helpers for the 8-requester arbiter.
package arb_pkg;

  localparam int N      = 8;
  localparam int IDX_W  = $clog2(N);
  localparam int HOLD_W = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  function automatic logic [N-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    logic [N-1:0] oh;
    oh      = {N{1'b0}};
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner picker: rotate the candidates, priority-encode, un-rotate.
module arb_pick
  import arb_pkg::*;
(
  input  logic [N-1:0]     cand,
  input  logic [IDX_W-1:0] ptr,
  input  logic             fixed_pri,
  output logic [IDX_W-1:0] win_id,
  output logic             found
);

  logic [2*N-1:0]   shifted_s;
  logic [N-1:0]     rev_s;
  logic [N-1:0]     rot_s;
  logic [IDX_W-1:0] lsb_s;

  // Fixed mode bit-reverses so the highest index lands at position 0;
  // round-robin rotates so ptr lands at position 0.
  always_comb begin
    shifted_s = {cand, cand} >> ptr;
    rev_s     = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      rev_s[i] = cand[N-1-i];
    end
    if (fixed_pri) begin
      rot_s = rev_s;
    end else begin
      rot_s = shifted_s[N-1:0];
    end
    lsb_s = {IDX_W{1'b0}};
    for (int i = N - 1; i >= 0; i--) begin
      lsb_s = rot_s[i] ? IDX_W'(i) : lsb_s;
    end
    if (fixed_pri) begin
      win_id = IDX_W'(N - 1) - lsb_s;
    end else begin
      win_id = lsb_s + ptr;
    end
    found = |cand;
  end

endmodule

// File: rtl/rr_arbiter8.sv
// 8-requester arbiter with fixed-priority or round-robin selection and a
// hold-limit timeout that forces handoff when others are waiting.
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             fixed_pri,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_id,
  output logic             gnt_valid
);

  arb_state_t        state_r;
  logic [N-1:0]      gnt_r;
  logic [IDX_W-1:0]  gnt_id_r;
  logic              gnt_valid_r;
  logic [IDX_W-1:0]  ptr_r;
  logic [HOLD_W-1:0] hold_cnt_r;

  logic              owner_req_s;
  logic              hold_at_limit_s;
  logic [N-1:0]      cand_s;
  logic [IDX_W-1:0]  win_s;
  logic              found_s;

  // While the owner still requests, only the others may compete (timeout
  // handoff); otherwise the raw request vector is the candidate set.
  always_comb begin
    owner_req_s     = req[gnt_id_r];
    hold_at_limit_s = (hold_cnt_r == HOLD_W'(MAX_HOLD - 1));
    if ((state_r == GRANT) && owner_req_s) begin
      cand_s = req & ~gnt_r;
    end else begin
      cand_s = req;
    end
  end

  arb_pick u_pick (
    .cand      (cand_s),
    .ptr       (ptr_r),
    .fixed_pri (fixed_pri),
    .win_id    (win_s),
    .found     (found_s)
  );

  // Grant state machine with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      gnt_r       <= {N{1'b0}};
      gnt_id_r    <= {IDX_W{1'b0}};
      gnt_valid_r <= 1'b0;
      ptr_r       <= {IDX_W{1'b0}};
      hold_cnt_r  <= {HOLD_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (found_s) begin
            state_r     <= GRANT;
            gnt_r       <= idx_to_onehot(win_s);
            gnt_id_r    <= win_s;
            gnt_valid_r <= 1'b1;
            ptr_r       <= win_s + IDX_W'(1);
            hold_cnt_r  <= {HOLD_W{1'b0}};
          end else begin
            state_r     <= IDLE;
            gnt_r       <= {N{1'b0}};
            gnt_id_r    <= {IDX_W{1'b0}};
            gnt_valid_r <= 1'b0;
            hold_cnt_r  <= {HOLD_W{1'b0}};
          end
        end
        GRANT: begin
          if (!owner_req_s) begin
            if (found_s) begin
              gnt_r       <= idx_to_onehot(win_s);
              gnt_id_r    <= win_s;
              gnt_valid_r <= 1'b1;
              ptr_r       <= win_s + IDX_W'(1);
              hold_cnt_r  <= {HOLD_W{1'b0}};
            end else begin
              state_r     <= IDLE;
              gnt_r       <= {N{1'b0}};
              gnt_id_r    <= {IDX_W{1'b0}};
              gnt_valid_r <= 1'b0;
              hold_cnt_r  <= {HOLD_W{1'b0}};
            end
          end else if (hold_at_limit_s) begin
            if (found_s) begin
              gnt_r      <= idx_to_onehot(win_s);
              gnt_id_r   <= win_s;
              ptr_r      <= win_s + IDX_W'(1);
              hold_cnt_r <= {HOLD_W{1'b0}};
            end else begin
              hold_cnt_r <= {HOLD_W{1'b0}};
            end
          end else begin
            hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
          end
        end
        default: begin
          state_r     <= IDLE;
          gnt_r       <= {N{1'b0}};
          gnt_id_r    <= {IDX_W{1'b0}};
          gnt_valid_r <= 1'b0;
          ptr_r       <= {IDX_W{1'b0}};
          hold_cnt_r  <= {HOLD_W{1'b0}};
        end
      endcase
    end
  end

  assign gnt       = gnt_r;
  assign gnt_id    = gnt_id_r;
  assign gnt_valid = gnt_valid_r;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8: directed scenarios plus random traffic
// compared against a behavioural owner/pointer/hold-time model.
module tb_rr_arbiter8;

  localparam int MH = 4;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       fixed_pri;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;

  int checks;
  int errors;

  // Reference model: current owner (-1 = idle), rotating start point, cycles held.
  int m_owner;
  int m_ptr;
  int m_hold;

  rr_arbiter8 #(.MAX_HOLD(MH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .fixed_pri (fixed_pri),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pick(input logic [7:0] c, input int p, input logic f);
    if (f) begin
      for (int i = 7; i >= 0; i--) if (c[i]) return i;
    end else begin
      for (int k = 0; k < 8; k++) if (c[(p + k) % 8]) return (p + k) % 8;
    end
    return -1;
  endfunction

  function automatic void take(input int w);
    m_owner = w;
    m_hold  = 0;
    m_ptr   = (w + 1) % 8;
  endfunction

  function automatic void model_update(input logic [7:0] r, input logic f, input logic rs);
    logic [7:0] others;
    int w;
    if (rs) begin
      m_owner = -1; m_ptr = 0; m_hold = 0;
    end else if (m_owner < 0) begin
      w = pick(r, m_ptr, f);
      if (w >= 0) take(w);
    end else if (!r[m_owner]) begin
      w = pick(r, m_ptr, f);
      if (w >= 0) take(w);
      else m_owner = -1;
    end else if (m_hold == MH - 1) begin
      others = r;
      others[m_owner] = 1'b0;
      w = pick(others, m_ptr, f);
      if (w >= 0) take(w);
      else m_hold = 0;
    end else begin
      m_hold = m_hold + 1;
    end
  endfunction

  function automatic logic [11:0] exp_out();
    if (m_owner < 0) return 12'h000;
    return {8'h01 << m_owner, 3'(m_owner), 1'b1};
  endfunction

  task automatic step(input logic [7:0] r, input logic f, input logic rs);
    req = r; fixed_pri = f; rst = rs;
    @(posedge clk);
    model_update(r, f, rs);
    #1;
  endtask

  task automatic test_reset();
    step(8'h00, 1'b0, 1'b1);
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (gnt !== 8'h00 || gnt_id !== 3'd0 || gnt_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d got gnt=%h id=%0d v=%b want 00/0/0", c, gnt, gnt_id, gnt_valid);
      end
      step(8'h00, 1'b0, 1'b0);
    end
  endtask

  task automatic test_fixed_priority();
    step(8'h00, 1'b1, 1'b1);
    step(8'b0001_0101, 1'b1, 1'b0);
    checks++;
    if (gnt !== 8'h10 || gnt_id !== 3'd4 || gnt_valid !== 1'b1) begin
      errors++;
      $display("FAIL fixed_first got gnt=%h id=%0d v=%b want 10/4/1", gnt, gnt_id, gnt_valid);
    end
    step(8'b0000_0101, 1'b1, 1'b0);
    checks++;
    if (gnt !== 8'h04 || gnt_id !== 3'd2 || gnt_valid !== 1'b1) begin
      errors++;
      $display("FAIL fixed_release got gnt=%h id=%0d v=%b want 04/2/1", gnt, gnt_id, gnt_valid);
    end
    step(8'h00, 1'b1, 1'b0);
    checks++;
    if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin
      errors++;
      $display("FAIL fixed_idle got gnt=%h v=%b want 00/0", gnt, gnt_valid);
    end
  endtask

  task automatic test_back_to_back();
    step(8'h00, 1'b0, 1'b1);
    step(8'hFF, 1'b0, 1'b0);
    checks++;
    if (gnt_id !== 3'd0 || gnt_valid !== 1'b1) begin
      errors++;
      $display("FAIL rr_start got id=%0d v=%b want 0/1", gnt_id, gnt_valid);
    end
    for (int k = 1; k <= 8; k++) begin
      step(8'hFF & ~(8'h01 << ((k - 1) % 8)), 1'b0, 1'b0);
      checks++;
      if (gnt_id !== 3'(k % 8) || gnt_valid !== 1'b1 || gnt !== (8'h01 << (k % 8))) begin
        errors++;
        $display("FAIL rr_handoff k=%0d got id=%0d v=%b gnt=%h want id=%0d v=1", k, gnt_id, gnt_valid, gnt, k % 8);
      end
    end
  endtask

  task automatic test_timeout();
    step(8'h00, 1'b0, 1'b1);
    step(8'h28, 1'b0, 1'b0);
    for (int c = 1; c <= 5; c++) begin
      checks++;
      if (gnt_id !== ((c <= 4) ? 3'd3 : 3'd5) || gnt_valid !== 1'b1) begin
        errors++;
        $display("FAIL timeout_handoff cyc=%0d got id=%0d want %0d", c, gnt_id, (c <= 4) ? 3 : 5);
      end
      if (c < 5) step(8'h28, 1'b0, 1'b0);
    end
    for (int c = 0; c < 20; c++) begin
      step(8'h08, 1'b0, 1'b0);
      checks++;
      if (gnt_id !== 3'd3 || gnt_valid !== 1'b1) begin
        errors++;
        $display("FAIL timeout_alone cyc=%0d got id=%0d v=%b want 3/1", c, gnt_id, gnt_valid);
      end
    end
  endtask

  task automatic test_reset_mid_grant();
    step(8'h00, 1'b1, 1'b1);
    step(8'h40, 1'b1, 1'b0);
    checks++;
    if (gnt_id !== 3'd6) begin
      errors++;
      $display("FAIL mid_rst_setup got id=%0d want 6", gnt_id);
    end
    step(8'hFF, 1'b1, 1'b1);
    checks++;
    if (gnt !== 8'h00 || gnt_valid !== 1'b0 || gnt_id !== 3'd0) begin
      errors++;
      $display("FAIL mid_rst_drop got gnt=%h id=%0d v=%b want 00/0/0", gnt, gnt_id, gnt_valid);
    end
    step(8'hFF, 1'b0, 1'b0);
    checks++;
    if (gnt_id !== 3'd0 || gnt_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_rst_ptr got id=%0d v=%b want 0/1", gnt_id, gnt_valid);
    end
  endtask

  task automatic test_mode_toggle();
    step(8'h00, 1'b0, 1'b1);
    step(8'h02, 1'b0, 1'b0);
    step(8'h82, 1'b1, 1'b0);
    checks++;
    if (gnt_id !== 3'd1) begin
      errors++;
      $display("FAIL toggle_hold1 got id=%0d want 1", gnt_id);
    end
    step(8'h82, 1'b0, 1'b0);
    checks++;
    if (gnt_id !== 3'd1) begin
      errors++;
      $display("FAIL toggle_hold2 got id=%0d want 1", gnt_id);
    end
    step(8'h84, 1'b1, 1'b0);
    checks++;
    if (gnt_id !== 3'd7 || gnt !== 8'h80) begin
      errors++;
      $display("FAIL toggle_release got id=%0d gnt=%h want 7/80", gnt_id, gnt);
    end
  endtask

  task automatic test_random();
    logic [7:0] r;
    logic       f;
    logic       rs;
    r = 8'h00; f = 1'b0;
    step(8'h00, 1'b0, 1'b1);
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) r = r ^ (8'h01 << $urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) r = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 9) == 0) f = ~f;
      rs = ($urandom_range(0, 99) == 0);
      step(r, f, rs);
      checks++;
      if ({gnt, gnt_id, gnt_valid} !== exp_out()) begin
        errors++;
        $display("FAIL random_model cyc=%0d req=%h fp=%b got gnt=%h id=%0d v=%b want %h",
                 c, r, f, gnt, gnt_id, gnt_valid, exp_out());
      end
      checks++;
      if (!$onehot0(gnt) || gnt_valid !== (|gnt)) begin
        errors++;
        $display("FAIL random_invariant cyc=%0d got gnt=%h v=%b", c, gnt, gnt_valid);
      end
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    m_owner = -1; m_ptr = 0; m_hold = 0;
    rst = 1'b1; req = 8'h00; fixed_pri = 1'b0;
    test_reset();
    test_fixed_priority();
    test_back_to_back();
    test_timeout();
    test_reset_mid_grant();
    test_mode_toggle();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
